seq_fixdiv: RTL and testbench

Parametrised multi-cycle fixed-point divider: a controller FSM plus an integrated restoring-division datapath. Signed or unsigned per operation, W-bit operands with F fractional bits, one quotient bit per clock. Divide-by-zero and overflow are flagged and the quotient saturates. It is the general successor to the fixed-iteration divider controller and is used wherever the datapath needs Q-format division behind a start/done handshake.

---
 rtl/seq_fixdiv_pkg.sv | 36 +++
 rtl/seq_fixdiv_if.sv | 34 +++
 rtl/seq_fixdiv_datapath.sv | 93 +++++++++
 rtl/seq_fixdiv.sv | 150 +++++++++++++++
 tb/tb_seq_fixdiv.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_fixdiv_pkg.sv
// seq_fixdiv shared types and helpers.
// Optional remainder output: SEQ_FIXDIV_REMAINDER_EN.
package seq_fixdiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Magnitude of a value already zero-extended to 32 bits.
  function automatic logic [31:0] abs_val(
    input logic [31:0] x,
    input logic        neg
  );
    return neg ? 32'(-x) : x;
  endfunction

  // Saturated quotient for a w-bit result.
  function automatic logic [31:0] sat_val(
    input int   w,
    input logic sgn,
    input logic neg
  );
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    if (!sgn)
      return ones >> (32 - w);
    if (neg)
      return 32'd1 << (w - 1);
    return ones >> (33 - w);
  endfunction

endpackage

// File: rtl/seq_fixdiv_if.sv
// seq_fixdiv start/done request bundle.
// rem exists only with SEQ_FIXDIV_REMAINDER_EN.
interface seq_fixdiv_if #(
  parameter int W = 8
);
  logic         start;
  logic         sgn;
  logic [W-1:0] a;
  logic [W-1:0] d;
  logic [W-1:0] q;
`ifdef SEQ_FIXDIV_REMAINDER_EN
  logic [W-1:0] rem;
`endif
  logic         busy;
  logic         done;
  logic         ov;
  logic         dz;

  modport master (
    output start, sgn, a, d,
    input  q, busy, done, ov, dz
`ifdef SEQ_FIXDIV_REMAINDER_EN
    , input rem
`endif
  );

  modport slave (
    input  start, sgn, a, d,
    output q, busy, done, ov, dz
`ifdef SEQ_FIXDIV_REMAINDER_EN
    , output rem
`endif
  );
endinterface

// File: rtl/seq_fixdiv_datapath.sv
// seq_fixdiv restoring-division datapath.
// Signed remainder port only with SEQ_FIXDIV_REMAINDER_EN.
module seq_fixdiv_datapath
  import seq_fixdiv_pkg::*;
#(
  parameter int W = 8,
  parameter int F = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          capture,
  input  logic          init,
  input  logic          step,
  input  logic          sgn,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  d,
  output logic          sgn_q,
  output logic          sa,
  output logic          neg,
  output logic          dzero,
  output logic          last,
  output logic [W+F-1:0] mag
`ifdef SEQ_FIXDIV_REMAINDER_EN
  , output logic [W-1:0] rmd
`endif
);
  localparam int WF = W + F;
  localparam int CW = $clog2(WF + 1);

  logic [W-1:0]  a_q;
  logic [W-1:0]  d_q;
  logic [W-1:0]  dmag;
  logic [W-1:0]  amag;
  logic [W-1:0]  dm;
  logic [WF-1:0] dvd;
  logic [WF-1:0] quo;
  logic [W-1:0]  rmdr;
  logic [CW-1:0] cnt;
  logic [W:0]    shifted;
  logic [W-1:0]  diff;
  logic          sd;
  logic          ge;

  assign sa    = sgn_q & a_q[W-1];
  assign sd    = sgn_q & d_q[W-1];
  assign neg   = sa ^ sd;
  assign dzero = (d_q == '0);
  assign last  = (cnt == CW'(WF - 1));
  assign amag  = W'(abs_val(32'(a_q), sa));
  assign dm    = W'(abs_val(32'(d_q), sd));
  assign mag   = quo;

  // Remainder fits W bits once shifted < 2*|d|.
  assign shifted = {rmdr, dvd[WF-1]};
  assign ge      = (shifted >= {1'b0, dmag});
  assign diff    = shifted[W-1:0] - dmag;

`ifdef SEQ_FIXDIV_REMAINDER_EN
  assign rmd = sa ? -rmdr : rmdr;
`endif

  // Operand capture, setup and one restoring step per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      d_q   <= '0;
      sgn_q <= 1'b0;
      dmag  <= '0;
      dvd   <= '0;
      quo   <= '0;
      rmdr  <= '0;
      cnt   <= '0;
    end else begin
      if (capture) begin
        a_q   <= a;
        d_q   <= d;
        sgn_q <= sgn;
      end
      if (init) begin
        dmag <= dm;
        dvd  <= WF'(amag) << F;
        rmdr <= '0;
        quo  <= '0;
        cnt  <= '0;
      end else if (step) begin
        rmdr <= ge ? diff : shifted[W-1:0];
        dvd  <= dvd << 1;
        quo  <= {quo[WF-2:0], ge};
        cnt  <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/seq_fixdiv.sv
// seq_fixdiv controller FSM and output registers.
// Remainder output enabled by SEQ_FIXDIV_REMAINDER_EN.
module seq_fixdiv
  import seq_fixdiv_pkg::*;
#(
  parameter int W = 8,
  parameter int F = 4
) (
  input logic         clk,
  input logic         rst,
  seq_fixdiv_if.slave bus
);
  localparam int WF = W + F;
  localparam logic [WF-1:0] POS_LIM =
    WF'({1'b0, {(W-1){1'b1}}});
  localparam logic [WF-1:0] NEG_LIM =
    WF'({1'b1, {(W-1){1'b0}}});
  localparam logic [WF-1:0] U_LIM =
    WF'({W{1'b1}});

  state_t        state;
  state_t        nxt;
  logic          capture;
  logic          init;
  logic          step;
  logic          sgn_q;
  logic          sa;
  logic          neg;
  logic          dzero;
  logic          last;
  logic          ovf;
  logic [WF-1:0] mag;
  logic [W-1:0]  sat;
  logic [W-1:0]  qv;
  logic [W-1:0]  q_r;
  logic          busy_r;
  logic          done_r;
  logic          ov_r;
  logic          dz_r;
`ifdef SEQ_FIXDIV_REMAINDER_EN
  logic [W-1:0]  rmd;
  logic [W-1:0]  rem_r;
`endif

  assign capture = (state == ST_IDLE) && bus.start;
  assign init    = (state == ST_LOAD);
  assign step    = (state == ST_DIV);

  seq_fixdiv_datapath #(
    .W (W),
    .F (F)
  ) u_dp (
    .clk     (clk),
    .rst     (rst),
    .capture (capture),
    .init    (init),
    .step    (step),
    .sgn     (bus.sgn),
    .a       (bus.a),
    .d       (bus.d),
    .sgn_q   (sgn_q),
    .sa      (sa),
    .neg     (neg),
    .dzero   (dzero),
    .last    (last),
    .mag     (mag)
`ifdef SEQ_FIXDIV_REMAINDER_EN
    , .rmd   (rmd)
`endif
  );

  // Saturation follows the dividend sign for both dz and ov.
  assign sat = W'(sat_val(W, sgn_q, sa));
  assign qv  = neg ? -mag[W-1:0] : mag[W-1:0];
  assign ovf = sgn_q ? (neg ? (mag > NEG_LIM)
                            : (mag > POS_LIM))
                     : (mag > U_LIM);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= ST_IDLE;
    else
      state <= nxt;
  end

  // Next state; dz skips DIV and commits via FIX.
  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: if (bus.start) nxt = ST_LOAD;
      ST_LOAD: nxt = dzero ? ST_FIX : ST_DIV;
      ST_DIV:  if (last) nxt = ST_FIX;
      ST_FIX:  nxt = ST_DONE;
      ST_DONE: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // Registered status and result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      ov_r   <= 1'b0;
      dz_r   <= 1'b0;
`ifdef SEQ_FIXDIV_REMAINDER_EN
      rem_r  <= '0;
`endif
    end else begin
      busy_r <= (nxt != ST_IDLE);
      done_r <= (nxt == ST_DONE);
      if (capture) begin
        ov_r <= 1'b0;
        dz_r <= 1'b0;
      end
      if (init && dzero) begin
        dz_r  <= 1'b1;
        q_r   <= sat;
`ifdef SEQ_FIXDIV_REMAINDER_EN
        rem_r <= '0;
`endif
      end
      if ((state == ST_FIX) && !dz_r) begin
        if (ovf) begin
          ov_r  <= 1'b1;
          q_r   <= sat;
`ifdef SEQ_FIXDIV_REMAINDER_EN
          rem_r <= '0;
`endif
        end else begin
          q_r   <= qv;
`ifdef SEQ_FIXDIV_REMAINDER_EN
          rem_r <= rmd;
`endif
        end
      end
    end
  end

  assign bus.q    = q_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.ov   = ov_r;
  assign bus.dz   = dz_r;
`ifdef SEQ_FIXDIV_REMAINDER_EN
  assign bus.rem  = rem_r;
`endif
endmodule

// File: tb/tb_seq_fixdiv.sv
// seq_fixdiv bench: random and directed ops vs an arithmetic model.
// Checks rem too when SEQ_FIXDIV_REMAINDER_EN is defined.
module tb_seq_fixdiv;
  localparam int W = 8;
  localparam int F = 4;

  typedef struct {
    logic [W-1:0] q;
    logic         ov;
    logic         dz;
    logic [W-1:0] rem;
    int           acc;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   n_acc = 0;
  int   n_done = 0;
  int   edge_cnt = 0;
  exp_t exp_q[$];
  int   acc_hist[$];

  seq_fixdiv_if #(.W(W)) bus();

  seq_fixdiv #(.W(W), .F(F)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic exp_t model(
    input logic         s,
    input logic [W-1:0] av,
    input logic [W-1:0] dv
  );
    exp_t         e;
    longint       na, nd, num, qq, rr, lo, hi;
    logic [W-1:0] mn, st;
    if (s) begin
      na = longint'($signed(av));
      nd = longint'($signed(dv));
      lo = -(64'sd1 <<< (W - 1));
      hi = (64'sd1 <<< (W - 1)) - 1;
    end else begin
      na = longint'(av);
      nd = longint'(dv);
      lo = 0;
      hi = (64'sd1 <<< W) - 1;
    end
    mn = '0;
    mn[W-1] = 1'b1;
    if (!s)
      st = '1;
    else if (na < 0)
      st = mn;
    else
      st = ~mn;
    e.ov = 1'b0;
    e.dz = 1'b0;
    e.acc = 0;
    if (nd == 0) begin
      e.dz = 1'b1;
      e.q = st;
      e.rem = '0;
      e.lat = 2;
    end else begin
      num = na * (64'sd1 <<< F);
      qq = num / nd;
      rr = num % nd;
      e.lat = W + F + 2;
      if (qq < lo || qq > hi) begin
        e.ov = 1'b1;
        e.q = st;
        e.rem = '0;
      end else begin
        e.q = qq[W-1:0];
        e.rem = rr[W-1:0];
      end
    end
    return e;
  endfunction

  task automatic check(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] want
  );
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, want);
    end
  endtask

  // Single compare/monitor process on the falling edge.
  always @(negedge clk) begin : cmp
    exp_t e;
    if (bus.done) begin
      n_done++;
      check("done_busy", 32'(bus.busy), 32'd1);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL stray_done: got done=1 want 0");
      end else begin
        e = exp_q.pop_front();
        check("q", 32'(bus.q), 32'(e.q));
        check("ov", 32'(bus.ov), 32'(e.ov));
        check("dz", 32'(bus.dz), 32'(e.dz));
`ifdef SEQ_FIXDIV_REMAINDER_EN
        check("rem", 32'(bus.rem), 32'(e.rem));
`endif
        check("latency", 32'(edge_cnt - e.acc), 32'(e.lat));
      end
    end
    if (rst && bus.start && !bus.busy) begin
      e = model(bus.sgn, bus.a, bus.d);
      e.acc = edge_cnt + 1;
      exp_q.push_back(e);
      acc_hist.push_back(edge_cnt + 1);
      n_acc++;
    end
  end

  task automatic wait_acc(input int t);
    int i;
    i = 0;
    while (n_acc < t && i < 200) begin
      @(posedge clk);
      i++;
    end
    if (n_acc < t) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got %0d want %0d", n_acc, t);
    end
  endtask

  task automatic wait_done(input int t);
    int i;
    i = 0;
    while (n_done < t && i < 200) begin
      @(posedge clk);
      i++;
    end
    if (n_done < t) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got %0d want %0d", n_done, t);
    end
  endtask

  task automatic op(
    input logic         s,
    input logic [W-1:0] av,
    input logic [W-1:0] dv
  );
    int ta;
    int td;
    ta = n_acc + 1;
    td = n_done + 1;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.sgn = s;
    bus.a = av;
    bus.d = dv;
    wait_acc(ta);
    #1 bus.start = 1'b0;
    wait_done(td);
  endtask

  initial begin : main
    exp_t m;
    int   nd0;
    int   na0;
    logic s;
    logic [W-1:0] ra, rd;
    bus.start = 1'b0;
    bus.sgn = 1'b0;
    bus.a = '0;
    bus.d = '0;

    m = model(1'b1, 8'h30, 8'h20);
    check("pin_q_1p5", 32'(m.q), 32'h18);
    m = model(1'b1, 8'hF0, 8'h30);
    check("pin_q_neg", 32'(m.q), 32'hFB);
    check("pin_rem_neg", 32'(m.rem), 32'hF0);
    m = model(1'b1, 8'h70, 8'h08);
    check("pin_ov", 32'(m.ov), 32'd1);
    check("pin_ov_q", 32'(m.q), 32'h7F);
    m = model(1'b0, 8'hF0, 8'h10);
    check("pin_uq", 32'(m.q), 32'hF0);
    m = model(1'b1, 8'hC0, 8'h00);
    check("pin_dz_q", 32'(m.q), 32'h80);
    m = model(1'b1, 8'h10, 8'h30);
    check("pin_q_small", 32'(m.q), 32'h05);

    #12;
    check("rst_q", 32'(bus.q), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_ov", 32'(bus.ov), 32'd0);
    check("rst_dz", 32'(bus.dz), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    op(1'b1, 8'h30, 8'h20);
    op(1'b1, 8'hF0, 8'h30);
    op(1'b1, 8'h70, 8'h08);
    op(1'b0, 8'hF0, 8'h10);
    op(1'b1, 8'hC0, 8'h00);
    op(1'b1, 8'h80, 8'hFF);
    op(1'b1, 8'h80, 8'h10);
    op(1'b1, 8'h7F, 8'h10);
    op(1'b0, 8'hFF, 8'h00);

    nd0 = n_done;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.sgn = 1'b1;
    bus.a = 8'h30;
    bus.d = 8'h20;
    wait_acc(n_acc + 1);
    #1 bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    #1;
    check("abort_q", 32'(bus.q), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_ov", 32'(bus.ov), 32'd0);
    check("abort_dz", 32'(bus.dz), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    op(1'b1, 8'h10, 8'h30);
    check("abort_no_done", 32'(n_done - nd0), 32'd1);

    na0 = n_acc;
    nd0 = n_done;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.sgn = 1'b1;
    bus.a = 8'h30;
    bus.d = 8'h20;
    wait_acc(na0 + 1);
    #1;
    bus.sgn = 1'b0;
    bus.a = 8'hF0;
    bus.d = 8'h10;
    wait_acc(na0 + 2);
    #1 bus.start = 1'b0;
    wait_done(nd0 + 2);
    repeat (4) @(posedge clk);
    check("b2b_dones", 32'(n_done - nd0), 32'd2);
    check("b2b_gap",
          32'(acc_hist[acc_hist.size()-1] - acc_hist[acc_hist.size()-2]),
          32'(W + F + 4));

    repeat (40) begin
      s = 1'($urandom);
      ra = W'($urandom);
      if ($urandom_range(0, 7) == 0)
        rd = '0;
      else if ($urandom_range(0, 3) == 0)
        rd = W'($urandom_range(1, 15));
      else
        rd = W'($urandom);
      op(s, ra, rd);
    end

    repeat (4) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
